// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer; in_ready depends only on registered state.
// Optional PIPE_STAGE_SKID_PERF_EN adds stall_cnt/bubble_cnt performance counters.
module pipe_stage_skid #(
   parameter int unsigned          DATA_W  = 32,
   parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_SKID_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic              in_fire;
   logic              out_fire;

   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != TWO);
   assign occupancy = state;
   assign out_data  = main_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // main_q is always the head beat; skid_q only holds the second beat while in TWO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= RST_VAL;
         skid_q <= RST_VAL;
      end else if (flush) begin
         state  <= EMPTY;
         main_q <= RST_VAL;
         skid_q <= RST_VAL;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state  <= ONE;
                  main_q <= in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= in_data;
               end else if (in_fire) begin
                  state  <= TWO;
                  skid_q <= in_data;
               end else if (out_fire) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  state  <= ONE;
                  main_q <= skid_q;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_SKID_PERF_EN
   // Counters survive flush so that flush-heavy phases still show up in the totals
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (!out_valid && !flush) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed plan steps plus random traffic against a queue model.
// Counter checks are included when PIPE_STAGE_SKID_PERF_EN is defined.
module tb_pipe_stage_skid;

   localparam int unsigned       DATA_W  = 32;
   localparam logic [DATA_W-1:0] RST_VAL = '0;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
`ifdef PIPE_STAGE_SKID_PERF_EN
   logic [31:0]       stall_cnt;
   logic [31:0]       bubble_cnt;
`endif

   pipe_stage_skid #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_SKID_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: FIFO of held beats plus counter totals
   logic [DATA_W-1:0] q[$];
   bit                clean;
   int unsigned       m_stall;
   int unsigned       m_bubble;
   int                errors = 0;
   int                checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      check("occupancy", 64'(occupancy), 64'(q.size()));
      if (q.size() > 0) check("out_data", 64'(out_data), 64'(q[0]));
      else if (clean) check("out_data_rst", 64'(out_data), 64'(RST_VAL));
`ifdef PIPE_STAGE_SKID_PERF_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`endif
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare
   task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
      bit acc;
      bit pop;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      acc = v && (q.size() < 2);
      pop = ordy && (q.size() > 0);
      if (q.size() > 0 && !ordy) m_stall++;
      if (q.size() == 0 && !fl) m_bubble++;
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
         clean = 1'b1;
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) begin
            q.push_back(d);
            clean = 1'b0;
         end
      end
      check_outputs();
   endtask

   task automatic model_reset();
      q.delete();
      clean    = 1'b1;
      m_stall  = 0;
      m_bubble = 0;
   endtask

   initial begin
      logic [DATA_W-1:0] pend;
      bit                has_pend;
      logic              v, ordy, fl;

      // 1. reset then idle
      model_reset();
      #12;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 2. streaming 1..8
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, DATA_W'(i), 1'b1, 1'b0);
         check("stream_data", 64'(out_data), 64'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);

      // 3. backpressure into the skid entry
      cycle(1'b1, 32'hA, 1'b0, 1'b0);
      cycle(1'b1, 32'hB, 1'b0, 1'b0);
      check("skid_full_ready", 64'(in_ready), 64'd0);
      cycle(1'b1, 32'hC, 1'b0, 1'b0);
      cycle(1'b1, 32'hC, 1'b1, 1'b0);
      check("skid_pop_b", 64'(out_data), 64'hB);
      cycle(1'b1, 32'hC, 1'b1, 1'b0);
      check("skid_pop_c", 64'(out_data), 64'hC);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // 4. flush while full with a beat offered
      cycle(1'b1, 32'h11, 1'b0, 1'b0);
      cycle(1'b1, 32'h22, 1'b0, 1'b0);
      cycle(1'b1, 32'hD, 1'b0, 1'b1);
      check("flush_occ", 64'(occupancy), 64'd0);
      cycle(1'b0, '0, 1'b1, 1'b0);

      // 5. async reset between edges
      cycle(1'b1, 32'h33, 1'b0, 1'b0);
      cycle(1'b1, 32'h44, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b0;
      model_reset();
      #1;
      check("async_rst_occ", 64'(occupancy), 64'd0);
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // 6. counters: one bubble, three stalls, one more bubble, then flush
      cycle(1'b1, 32'h55, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_PERF_EN
      check("perf_stall", 64'(stall_cnt), 64'd3);
      check("perf_bubble", 64'(bubble_cnt), 64'd2);
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("perf_stall_flush", 64'(stall_cnt), 64'd3);
      check("perf_bubble_flush", 64'(bubble_cnt), 64'd2);
`else
      cycle(1'b0, '0, 1'b0, 1'b1);
`endif

      // random traffic; upstream holds a refused beat until accepted
      has_pend = 1'b0;
      pend = '0;
      for (int n = 0; n < 400; n++) begin
         if (!has_pend && ($urandom_range(0, 3) != 0)) begin
            pend = DATA_W'($urandom);
            has_pend = 1'b1;
         end
         v    = has_pend;
         ordy = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 19) == 0);
         if (has_pend && (q.size() < 2 || fl)) has_pend = 1'b0;
         cycle(v, pend, ordy, fl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
